// File: rtl/meas_uart_tx_if.sv
// Measurement-result interface: CORDIC result inputs towards the UART framer
// and the serial line plus status pulses coming back out of it.
interface meas_uart_tx_if;
    logic        end_cordic;
    logic [15:0] data_sqrt;
    logic [18:0] angle;
    logic [5:0]  addr;
    logic [1:0]  method_state;
    logic        uart_txd;
    logic        busy;
    logic        end_send_uart;
    logic        overrun;

    modport master (
        output end_cordic,
        output data_sqrt,
        output angle,
        output addr,
        output method_state,
        input  uart_txd,
        input  busy,
        input  end_send_uart,
        input  overrun
    );

    modport slave (
        input  end_cordic,
        input  data_sqrt,
        input  angle,
        input  addr,
        input  method_state,
        output uart_txd,
        output busy,
        output end_send_uart,
        output overrun
    );
endinterface

// File: rtl/meas_uart_tx.sv
// Latches one impedance measurement into a 9-byte frame (header, payload,
// XOR checksum, CR) and sends it out as 8N1 serial, LSB first.
module meas_uart_tx #(
    parameter int unsigned BAUD_DIV = 434,
    parameter logic [7:0]  HEADER   = 8'hA5
) (
    input logic           clk,
    input logic           rst,
    meas_uart_tx_if.slave bus
);

    localparam logic [15:0] BIT_LAST  = 16'(BAUD_DIV - 1);
    localparam logic [3:0]  BYTE_LAST = 4'd8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        DONE
    } state_t;

    state_t      state_q,    state_d;
    logic [15:0] timer_q,    timer_d;
    logic [3:0]  byte_idx_q, byte_idx_d;
    logic [2:0]  bit_idx_q,  bit_idx_d;
    logic [71:0] frame_q,    frame_d;
    logic        txd_q,      txd_d;
    logic        busy_q,     busy_d;
    logic        end_q,      end_d;
    logic        overrun_q,  overrun_d;

    logic        accept_mode;
    logic        can_capture;
    logic        capture;
    logic        bit_done;
    logic [7:0]  mode_addr;
    logic [7:0]  chk;
    logic [7:0]  cur_byte;
    logic [71:0] new_frame;

    // DONE also accepts a capture so sweep frames can be chained without a gap.
    always_comb begin
        accept_mode = (bus.method_state != 2'b00);
        can_capture = (state_q == IDLE) || (state_q == DONE);
        capture     = bus.end_cordic && accept_mode && can_capture;
        bit_done    = (timer_q == BIT_LAST);
        mode_addr   = {bus.method_state, bus.addr};
        chk         = mode_addr ^ bus.data_sqrt[15:8] ^ bus.data_sqrt[7:0]
                    ^ {5'b00000, bus.angle[18:16]} ^ bus.angle[15:8] ^ bus.angle[7:0];
        new_frame   = {8'h0D, chk, bus.angle[7:0], bus.angle[15:8],
                       {5'b00000, bus.angle[18:16]}, bus.data_sqrt[7:0],
                       bus.data_sqrt[15:8], mode_addr, HEADER};
        cur_byte    = frame_q[{byte_idx_q, 3'b000} +: 8];
    end

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        byte_idx_d = byte_idx_q;
        bit_idx_d  = bit_idx_q;
        frame_d    = frame_q;
        txd_d      = txd_q;
        busy_d     = busy_q;
        end_d      = 1'b0;
        overrun_d  = bus.end_cordic && accept_mode && !can_capture;

        unique case (state_q)
            IDLE, DONE: begin
                if (capture) begin
                    state_d    = START;
                    frame_d    = new_frame;
                    timer_d    = 16'd0;
                    byte_idx_d = 4'd0;
                    bit_idx_d  = 3'd0;
                    txd_d      = 1'b0;
                    busy_d     = 1'b1;
                end else begin
                    state_d    = IDLE;
                    timer_d    = 16'd0;
                    byte_idx_d = 4'd0;
                    bit_idx_d  = 3'd0;
                    txd_d      = 1'b1;
                    busy_d     = 1'b0;
                end
            end
            START: begin
                if (bit_done) begin
                    state_d   = DATA;
                    timer_d   = 16'd0;
                    bit_idx_d = 3'd0;
                    txd_d     = cur_byte[0];
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end
            DATA: begin
                if (bit_done) begin
                    timer_d = 16'd0;
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                        txd_d   = 1'b1;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        txd_d     = cur_byte[bit_idx_q + 3'd1];
                    end
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end
            STOP: begin
                if (bit_done) begin
                    timer_d = 16'd0;
                    if (byte_idx_q == BYTE_LAST) begin
                        state_d = DONE;
                        end_d   = 1'b1;
                    end else begin
                        state_d    = START;
                        byte_idx_d = byte_idx_q + 4'd1;
                        txd_d      = 1'b0;
                    end
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end
            default: begin
                state_d = IDLE;
                txd_d   = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            timer_q    <= 16'd0;
            byte_idx_q <= 4'd0;
            bit_idx_q  <= 3'd0;
            frame_q    <= 72'd0;
            txd_q      <= 1'b1;
            busy_q     <= 1'b0;
            end_q      <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            byte_idx_q <= byte_idx_d;
            bit_idx_q  <= bit_idx_d;
            frame_q    <= frame_d;
            txd_q      <= txd_d;
            busy_q     <= busy_d;
            end_q      <= end_d;
            overrun_q  <= overrun_d;
        end
    end

    assign bus.uart_txd      = txd_q;
    assign bus.busy          = busy_q;
    assign bus.end_send_uart = end_q;
    assign bus.overrun       = overrun_q;

endmodule

// File: tb/tb_meas_uart_tx.sv
// Randomized scoreboard bench: stimulus pushes expected bytes/pulse cycles from a
// frame-timing model, a serial receiver monitor pops and compares them.
module tb_meas_uart_tx;

    localparam int B         = 4;
    localparam int FRAME_CYC = 90 * B + 1;
    localparam int BL        = 434;

    logic clk = 1'b0;
    logic rst;
    logic rst_l;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;

    meas_uart_tx_if bus ();
    meas_uart_tx_if bus_l ();

    meas_uart_tx #(.BAUD_DIV(B), .HEADER(8'hA5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    meas_uart_tx #(.BAUD_DIV(BL), .HEADER(8'hA5)) dut_l (
        .clk (clk),
        .rst (rst_l),
        .bus (bus_l)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] exp_bytes[$];
    int         exp_end[$];
    int         exp_ovr[$];
    int         model_free_at = 0;

    task automatic checkOutput(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Frame content derived directly from the byte layout and XOR checksum rule.
    task automatic pushFrame(input logic [15:0] ds, input logic [18:0] ang,
                             input logic [5:0] ad, input logic [1:0] ms);
        logic [7:0] f[9];
        f[0] = 8'hA5;
        f[1] = {ms, ad};
        f[2] = 8'(ds / 256);
        f[3] = 8'(ds % 256);
        f[4] = 8'(ang / 65536);
        f[5] = 8'((ang / 256) % 256);
        f[6] = 8'(ang % 256);
        f[7] = 8'h00;
        for (int i = 1; i <= 6; i++) f[7] = f[7] ^ f[i];
        f[8] = 8'h0D;
        for (int i = 0; i < 9; i++) exp_bytes.push_back(f[i]);
    endtask

    // Called at a negedge; the pulse is sampled by the DUT at posedge number cyc+1.
    task automatic applyStimulus(input logic [15:0] ds, input logic [18:0] ang,
                                 input logic [5:0] ad, input logic [1:0] ms);
        int x;
        x = cyc + 1;
        bus.data_sqrt    = ds;
        bus.angle        = ang;
        bus.addr         = ad;
        bus.method_state = ms;
        bus.end_cordic   = 1'b1;
        if (ms != 2'b00) begin
            if (x >= model_free_at) begin
                pushFrame(ds, ang, ad, ms);
                exp_end.push_back(x + 90 * B);
                model_free_at = x + FRAME_CYC;
            end else begin
                exp_ovr.push_back(x);
            end
        end
        @(negedge clk);
        bus.end_cordic   = 1'b0;
        bus.data_sqrt    = 16'($urandom);
        bus.angle        = 19'($urandom);
        bus.addr         = 6'($urandom);
        bus.method_state = 2'($urandom);
    endtask

    task automatic randomStimulus(input logic [1:0] ms);
        applyStimulus(16'($urandom), 19'($urandom), 6'($urandom), ms);
    endtask

    task automatic waitFree(input int extra);
        while (cyc + 1 < model_free_at + extra) @(negedge clk);
    endtask

    bit         rx_active = 1'b0;
    int         rx_cnt = 0;
    logic [7:0] rx_byte = 8'h00;
    int         busy_len = 0;

    always @(negedge clk) begin
        if (rst) begin
            checkOutput("reset uart_txd", int'(bus.uart_txd), 1);
            checkOutput("reset busy", int'(bus.busy), 0);
            checkOutput("reset end_send_uart", int'(bus.end_send_uart), 0);
            checkOutput("reset overrun", int'(bus.overrun), 0);
            rx_active = 1'b0;
            rx_cnt    = 0;
            busy_len  = 0;
            exp_bytes.delete();
            exp_end.delete();
            exp_ovr.delete();
        end else begin
            if (!bus.busy) checkOutput("idle uart_txd", int'(bus.uart_txd), 1);
            if (bus.busy) busy_len++;
            if (bus.end_send_uart) begin
                if (exp_end.size() > 0) checkOutput("end_send_uart cycle", cyc, exp_end.pop_front());
                else checkOutput("spurious end_send_uart", int'(bus.end_send_uart), 0);
                checkOutput("busy cycles per frame", busy_len, FRAME_CYC);
                busy_len = 0;
            end
            if (bus.overrun) begin
                if (exp_ovr.size() > 0) checkOutput("overrun cycle", cyc, exp_ovr.pop_front());
                else checkOutput("spurious overrun", int'(bus.overrun), 0);
            end
            if (!rx_active) begin
                if (bus.uart_txd == 1'b0) begin
                    rx_active = 1'b1;
                    rx_cnt    = 0;
                end
            end else begin
                rx_cnt++;
            end
            if (rx_active && (rx_cnt % B) == B / 2) begin
                int k;
                k = rx_cnt / B;
                if (k == 0) begin
                    checkOutput("start bit", int'(bus.uart_txd), 0);
                end else if (k <= 8) begin
                    rx_byte[k-1] = bus.uart_txd;
                end else begin
                    checkOutput("stop bit", int'(bus.uart_txd), 1);
                    if (exp_bytes.size() > 0) checkOutput("frame byte", int'(rx_byte), int'(exp_bytes.pop_front()));
                    else checkOutput("unexpected byte", int'(rx_byte), 256);
                    rx_active = 1'b0;
                end
            end
        end
    end

    bit l_started = 1'b0;
    bit l_run_done = 1'b0;
    int l_low = 0;
    int l_busy = 0;
    int l_ends = 0;

    always @(negedge clk) begin
        if (!rst_l) begin
            if (bus_l.busy) l_busy++;
            if (!l_started && bus_l.uart_txd == 1'b0) l_started = 1'b1;
            if (l_started && !l_run_done) begin
                if (bus_l.uart_txd == 1'b0) l_low++;
                else begin
                    checkOutput("start bit length at 434", l_low, BL);
                    l_run_done = 1'b1;
                end
            end
            if (bus_l.end_send_uart) begin
                checkOutput("frame cycles at 434", l_busy - 1, 90 * BL);
                l_ends++;
            end
        end
    end

    initial begin
        #(120000 * 10);
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst   = 1'b1;
        rst_l = 1'b1;
        bus.end_cordic     = 1'b0;
        bus.data_sqrt      = 16'h0;
        bus.angle          = 19'h0;
        bus.addr           = 6'h0;
        bus.method_state   = 2'b00;
        bus_l.end_cordic   = 1'b0;
        bus_l.data_sqrt    = 16'h0;
        bus_l.angle        = 19'h0;
        bus_l.addr         = 6'h0;
        bus_l.method_state = 2'b00;
        repeat (3) @(negedge clk);
        rst   = 1'b0;
        rst_l = 1'b0;

        $display("[TB] long-baud frame started on second instance");
        bus_l.data_sqrt    = 16'h1234;
        bus_l.angle        = 19'h5ABCD;
        bus_l.addr         = 6'd10;
        bus_l.method_state = 2'b10;
        bus_l.end_cordic   = 1'b1;
        @(negedge clk);
        bus_l.end_cordic   = 1'b0;

        $display("[TB] directed frame");
        applyStimulus(16'h1234, 19'h5ABCD, 6'd10, 2'b10);
        waitFree(5);

        $display("[TB] idle-mode pulse ignored");
        randomStimulus(2'b00);
        repeat (10) @(negedge clk);
        checkOutput("busy after idle-mode pulse", int'(bus.busy), 0);

        $display("[TB] overrun during frame");
        randomStimulus(2'b10);
        repeat (48) @(negedge clk);
        randomStimulus(2'b11);
        checkOutput("overrun pulse", int'(bus.overrun), 1);
        @(negedge clk);
        checkOutput("overrun width", int'(bus.overrun), 0);
        repeat (20) @(negedge clk);
        randomStimulus(2'b00);
        waitFree(5);

        $display("[TB] chained sweep of 37 frames");
        for (int i = 0; i < 37; i++) begin
            waitFree(0);
            applyStimulus(16'($urandom), 19'($urandom), 6'(i), 2'b11);
        end
        waitFree(5);

        $display("[TB] reset during byte 4");
        randomStimulus(2'b10);
        repeat (41 * B + 3) @(negedge clk);
        #2 rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        model_free_at = 0;
        randomStimulus(2'b10);
        waitFree(5);

        $display("[TB] random traffic");
        for (int i = 0; i < 12; i++) begin
            repeat ($urandom_range(0, 450)) @(negedge clk);
            randomStimulus(2'($urandom));
        end
        waitFree(10);

        while (cyc < 90 * BL + 200) @(negedge clk);
        checkOutput("bytes left unsent", exp_bytes.size(), 0);
        checkOutput("end_send_uart pulses missing", exp_end.size(), 0);
        checkOutput("overrun pulses missing", exp_ovr.size(), 0);
        checkOutput("end pulses at 434", l_ends, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/meas_uart_tx.md
MEAS_UART_TX -- requirements
Module: meas_uart_tx

Interface
REQ-001 Parameter: BAUD_DIV, default 434, clock cycles per UART bit (50 MHz / 115200); legal range 2..65535.
REQ-002 Parameter: HEADER, default 8'hA5, first byte of every frame.
REQ-003 Clocking: one clock; reset is asynchronous and active-high.
REQ-004 clk  input  1  system clock; all state on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 end_cordic  input  1  one-cycle pulse; magnitude/phase result valid this cycle.
REQ-007 data_sqrt  input  16  impedance magnitude, sampled on end_cordic.
REQ-008 angle  input  19  phase result, sampled on end_cordic.
REQ-009 addr  input  6  current frequency index, sampled on end_cordic.
REQ-010 method_state  input  2  measurement mode (00 idle, 10 single, 11 sweep), sampled on end_cordic.
REQ-011 uart_txd  output  1  serial line, 8N1, LSB first, idle high.
REQ-012 busy  output  1  high while a frame is latched or being sent.
REQ-013 end_send_uart  output  1  one-cycle pulse when a frame's final stop bit completes.
REQ-014 overrun  output  1  one-cycle pulse when an accepted-mode end_cordic arrives while busy.

Function
REQ-015 Frame: 9 bytes in order: HEADER, {method_state, addr}, data_sqrt[15:8], data_sqrt[7:0], {5'b0, angle[18:16]}, angle[15:8], angle[7:0], CHK, 8'h0D.
REQ-016 CHK: XOR of bytes 2..7 (the six bytes after HEADER); 8-bit, no carry.
REQ-017 Capture: end_cordic with method_state != 00 and busy low latches all inputs and CHK into a frame register in that cycle; busy goes high the next cycle.
REQ-018 end_cordic with method_state == 00: ignored; no capture, no overrun.
REQ-019 end_cordic while busy with method_state != 00: frame in flight unaffected, new data dropped, overrun pulses high for exactly the next cycle.
REQ-020 State machine: IDLE, START, DATA, STOP, DONE.
REQ-021 IDLE -> START on capture; uart_txd drives start bit (0) from the cycle busy rises.
REQ-022 Bit timer: counts 0..BAUD_DIV-1; each bit (start, 8 data, stop) held exactly BAUD_DIV cycles.
REQ-023 START -> DATA after BAUD_DIV cycles; DATA shifts bit 0 first, -> STOP after 8 bits.
REQ-024 STOP (uart_txd=1): after BAUD_DIV cycles, byte index < 8 -> START for next byte with no extra idle; byte index == 8 -> DONE.
REQ-025 DONE lasts one cycle: end_send_uart=1, then -> IDLE; busy falls in the cycle end_send_uart is high.
REQ-026 Frame duration: busy high for exactly 90*BAUD_DIV+1 cycles.
REQ-027 Back-to-back: end_cordic in the cycle end_send_uart is high is a capture, not an overrun; next start bit follows with no idle bit.
REQ-028 Byte index 0..8 and bit index 0..7 never wrap mid-frame; counters clear on entry to IDLE.
REQ-029 Inputs other than end_cordic are don't-care outside the capture cycle.

Reset
REQ-030 rst high: state IDLE, uart_txd=1, busy=0, end_send_uart=0, overrun=0, all counters and frame register cleared.
REQ-031 rst mid-frame: frame abandoned immediately, line returns high, no end_send_uart pulse.
REQ-032 First capture possible on the first rising edge after rst deasserts.

Verification (BAUD_DIV=4 unless stated)
REQ-033 end_cordic, data_sqrt=16'h1234, angle=19'h5ABCD, addr=6'd10, method_state=2'b10 -> bytes A5, 8A, 12, 34, 05, AB, CD, CHK=8A^12^34^05^AB^CD, 0D decoded; end_send_uart one pulse after 361 busy cycles.
REQ-034 end_cordic with method_state=00 -> uart_txd stays high, busy stays 0, overrun 0.
REQ-035 Second end_cordic 50 cycles into a frame -> overrun one-cycle pulse, first frame bytes unchanged, only one end_send_uart.
REQ-036 end_cordic coincident with end_send_uart (sweep, addr 0..36 chained) -> 37 contiguous frames, no idle gaps, 37 end_send_uart pulses, no overrun.
REQ-037 rst asserted during byte 4 data bits -> uart_txd=1 and busy=0 within the reset; no end_send_uart; a following capture sends a complete correct frame.
REQ-038 BAUD_DIV=434: start bit measured 434 cycles, whole frame 39060 cycles.
